// File: rtl/processor_pkg.sv
// Shared processor definitions used by the data-memory arbiter and datapath.
//   ADDR_W / DATA_W   : data-memory address and word widths
//   dmem_owner_t      : which port currently owns the data memory
//   dmem_arb_state_t  : arbiter FSM state encoding
package processor_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } dmem_owner_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker with a host lock override.
//   req_cpu, req_host : requests from the two ports
//   last_host         : 1 when the host was the last port served
//   lock              : host lock; only honoured once the host was served last
//   gnt               : one-hot grant, bit 0 = CPU, bit 1 = host (00 = nobody)
module rr_pick2 (
  input  logic       req_cpu,
  input  logic       req_host,
  input  logic       last_host,
  input  logic       lock,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock && last_host && req_host) begin
      // Host keeps ownership across a multi-word upload.
      gnt = 2'b10;
    end else if (req_cpu && req_host) begin
      gnt = last_host ? 2'b01 : 2'b10;
    end else if (req_cpu) begin
      gnt = 2'b01;
    end else if (req_host) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single synchronous-read data memory between
// the control unit (CPU port) and a host/debug port.
//   Clk, Reset                        : clock, async active-low reset
//   CPU_Req/We/Addr/WData, CPU_Ack    : CPU request port, one-cycle ack
//   Host_Req/We/Addr/WData, Host_Ack  : host request port, one-cycle ack
//   Host_Lock                         : host keeps ownership between accesses
//   RData                             : read data, valid while an ack is high
//   Mem_Addr/Mem_Wr/Mem_WData         : registered memory-side controls
//   Mem_RData                         : memory read data (one-cycle latency)
//   Gnt_Cpu, Gnt_Host                 : current owner during ACCESS/RESP
//
// state  | meaning
// IDLE   | no access in flight; sample requests, pick and latch a winner
// ACCESS | latched address/data/write strobe presented to memory
// RESP   | owner's ack high, memory read data returned, update last-served
module dmem_arbiter
  import processor_pkg::*;
#(
  parameter int ADDR_W = processor_pkg::ADDR_W,
  parameter int DATA_W = processor_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CPU_Req,
  input  logic              CPU_We,
  input  logic [ADDR_W-1:0] CPU_Addr,
  input  logic [DATA_W-1:0] CPU_WData,
  output logic              CPU_Ack,
  input  logic              Host_Req,
  input  logic              Host_We,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [DATA_W-1:0] Host_WData,
  output logic              Host_Ack,
  input  logic              Host_Lock,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Wr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Gnt_Cpu,
  output logic              Gnt_Host
);

  dmem_arb_state_t   state_q, state_d;
  dmem_owner_t       owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              host_ack_q, host_ack_d;
  logic              last_host_q, last_host_d;
  logic [1:0]        gnt;

  rr_pick2 u_pick (
    .req_cpu   (CPU_Req),
    .req_host  (Host_Req),
    .last_host (last_host_q),
    .lock      (Host_Lock),
    .gnt       (gnt)
  );

  // Last-served resets to host so the CPU wins the first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      host_ack_q  <= 1'b0;
      last_host_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_wr_q    <= mem_wr_d;
      cpu_ack_q   <= cpu_ack_d;
      host_ack_q  <= host_ack_d;
      last_host_q <= last_host_d;
    end
  end

  // Every memory-side and ack output is computed one state ahead so it comes
  // straight from a flop; requests never reach the memory pins combinationally.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_wr_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    host_ack_d  = 1'b0;
    last_host_d = last_host_q;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          owner_d  = OWN_CPU;
          addr_d   = CPU_Addr;
          wdata_d  = CPU_WData;
          mem_wr_d = CPU_We;
          state_d  = ACCESS;
        end else if (gnt[1]) begin
          owner_d  = OWN_HOST;
          addr_d   = Host_Addr;
          wdata_d  = Host_WData;
          mem_wr_d = Host_We;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        cpu_ack_d  = (owner_q == OWN_CPU);
        host_ack_d = (owner_q == OWN_HOST);
        state_d    = RESP;
      end
      RESP: begin
        last_host_d = (owner_q == OWN_HOST);
        owner_d     = OWN_NONE;
        state_d     = IDLE;
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
  end

  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;
  assign Mem_Wr    = mem_wr_q;
  assign CPU_Ack   = cpu_ack_q;
  assign Host_Ack  = host_ack_q;
  assign Gnt_Cpu   = (owner_q == OWN_CPU);
  assign Gnt_Host  = (owner_q == OWN_HOST);
  assign RData     = (cpu_ack_q || host_ack_q) ? Mem_RData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 256x16 synchronous
// memory model. "Cycle n" is sampled 1 time unit after the n-th rising edge
// following the cycle in which the request was first driven in IDLE.
module tb_dmem_arbiter;

  logic        Clk;
  logic        Reset;
  logic        CPU_Req, CPU_We;
  logic [7:0]  CPU_Addr;
  logic [15:0] CPU_WData;
  logic        CPU_Ack;
  logic        Host_Req, Host_We;
  logic [7:0]  Host_Addr;
  logic [15:0] Host_WData;
  logic        Host_Ack;
  logic        Host_Lock;
  logic [15:0] RData;
  logic [7:0]  Mem_Addr;
  logic        Mem_Wr;
  logic [15:0] Mem_WData;
  logic [15:0] Mem_RData;
  logic        Gnt_Cpu, Gnt_Host;

  int n_cmp;
  int n_err;

  logic [15:0] mem [256];
  logic [7:0]  up_addr [4];
  logic [15:0] up_data [4];

  dmem_arbiter dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .CPU_Req    (CPU_Req),
    .CPU_We     (CPU_We),
    .CPU_Addr   (CPU_Addr),
    .CPU_WData  (CPU_WData),
    .CPU_Ack    (CPU_Ack),
    .Host_Req   (Host_Req),
    .Host_We    (Host_We),
    .Host_Addr  (Host_Addr),
    .Host_WData (Host_WData),
    .Host_Ack   (Host_Ack),
    .Host_Lock  (Host_Lock),
    .RData      (RData),
    .Mem_Addr   (Mem_Addr),
    .Mem_Wr     (Mem_Wr),
    .Mem_WData  (Mem_WData),
    .Mem_RData  (Mem_RData),
    .Gnt_Cpu    (Gnt_Cpu),
    .Gnt_Host   (Gnt_Host)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read memory; a read during write returns the old word.
  always @(posedge Clk) begin
    if (Mem_Wr) mem[Mem_Addr] <= Mem_WData;
    Mem_RData <= mem[Mem_Addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " mem_wr"},   32'(Mem_Wr),   32'd0);
    chk({tag, " mem_addr"}, 32'(Mem_Addr), 32'd0);
    chk({tag, " cpu_ack"},  32'(CPU_Ack),  32'd0);
    chk({tag, " host_ack"}, 32'(Host_Ack), 32'd0);
    chk({tag, " gnt"},      32'({Gnt_Cpu, Gnt_Host}), 32'd0);
    chk({tag, " rdata"},    32'(RData),    32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h2A] = 16'h0C2A;
    mem[8'h3C] = 16'h0D3C;
    up_addr[0] = 8'h7E; up_data[0] = 16'hB17F;
    up_addr[1] = 8'h7F; up_data[1] = 16'h5A01;
    up_addr[2] = 8'h80; up_data[2] = 16'h5A02;
    up_addr[3] = 8'h81; up_data[3] = 16'h5A03;

    Reset = 1'b1;
    CPU_Req = 0; CPU_We = 0; CPU_Addr = '0; CPU_WData = '0;
    Host_Req = 0; Host_We = 0; Host_Addr = '0; Host_WData = '0; Host_Lock = 0;
    #2;
    do_reset();
    chk_idle_outputs("reset");

    // Reset mid-ACCESS on a CPU write.
    CPU_Req = 1; CPU_We = 1; CPU_Addr = 8'h10; CPU_WData = 16'h1234;
    tick();
    chk("midrst access mem_wr",   32'(Mem_Wr),   32'd1);
    chk("midrst access mem_addr", 32'(Mem_Addr), 32'h10);
    chk("midrst access gnt_cpu",  32'(Gnt_Cpu),  32'd1);
    Reset = 1'b0;
    #1;
    chk_idle_outputs("midrst async");
    CPU_Req = 0; CPU_We = 0;
    tick();
    chk("midrst held cpu_ack", 32'(CPU_Ack), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    tick();
    chk_idle_outputs("midrst after");

    // Host preload, then CPU read of the same word.
    Host_Req = 1; Host_We = 1; Host_Addr = 8'h1B; Host_WData = 16'h21BA;
    tick();
    chk("preload c1 mem_wr",    32'(Mem_Wr),    32'd1);
    chk("preload c1 mem_addr",  32'(Mem_Addr),  32'h1B);
    chk("preload c1 mem_wdata", 32'(Mem_WData), 32'h21BA);
    chk("preload c1 gnt_host",  32'(Gnt_Host),  32'd1);
    chk("preload c1 host_ack",  32'(Host_Ack),  32'd0);
    Host_Req = 0; Host_We = 0;
    tick();
    chk("preload c2 host_ack", 32'(Host_Ack), 32'd1);
    chk("preload c2 cpu_ack",  32'(CPU_Ack),  32'd0);
    chk("preload c2 mem_wr",   32'(Mem_Wr),   32'd0);
    tick();
    CPU_Req = 1; CPU_We = 0; CPU_Addr = 8'h1B;
    tick();
    chk("cpurd c1 cpu_ack", 32'(CPU_Ack), 32'd0);
    CPU_Req = 0;
    tick();
    chk("cpurd c2 cpu_ack", 32'(CPU_Ack), 32'd1);
    chk("cpurd c2 rdata",   32'(RData),   32'h21BA);
    tick();
    chk("cpurd c3 cpu_ack", 32'(CPU_Ack), 32'd0);
    chk("cpurd c3 rdata",   32'(RData),   32'd0);

    // Simultaneous reads right after reset: CPU wins the first tie.
    do_reset();
    CPU_Req = 1; CPU_We = 0; CPU_Addr = 8'h2A;
    Host_Req = 1; Host_We = 0; Host_Addr = 8'h3C;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("simul c%0d cpu_ack", c),  32'(CPU_Ack),  32'(c == 2));
      chk($sformatf("simul c%0d host_ack", c), 32'(Host_Ack), 32'(c == 5));
      if (c == 1) chk("simul c1 gnt_cpu", 32'(Gnt_Cpu), 32'd1);
      if (c == 2) begin
        chk("simul c2 rdata", 32'(RData), 32'h0C2A);
        CPU_Req = 0;
      end
      if (c == 5) begin
        chk("simul c5 rdata", 32'(RData), 32'h0D3C);
        Host_Req = 0;
      end
    end
    tick();

    // Both hold their requests: service alternates every 3 cycles.
    CPU_Req = 1; Host_Req = 1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk($sformatf("alt c%0d cpu_ack", c),  32'(CPU_Ack),  32'(c == 2 || c == 8));
      chk($sformatf("alt c%0d host_ack", c), 32'(Host_Ack), 32'(c == 5 || c == 11));
      if (c == 2 || c == 8)  chk($sformatf("alt c%0d rdata", c), 32'(RData), 32'h0C2A);
      if (c == 5 || c == 11) chk($sformatf("alt c%0d rdata", c), 32'(RData), 32'h0D3C);
    end
    CPU_Req = 0; Host_Req = 0;
    tick();

    // Host lock upload of four words while the CPU keeps requesting.
    CPU_Req = 1; CPU_We = 0; CPU_Addr = 8'h7E;
    Host_Lock = 1; Host_Req = 1; Host_We = 1;
    Host_Addr = up_addr[0]; Host_WData = up_data[0];
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) begin
        chk("lock c1 mem_wr",   32'(Mem_Wr),   32'd1);
        chk("lock c1 mem_addr", 32'(Mem_Addr), 32'h7E);
      end
      chk($sformatf("lock c%0d cpu_ack", c),  32'(CPU_Ack),  32'd0);
      chk($sformatf("lock c%0d host_ack", c), 32'(Host_Ack), 32'(c % 3 == 2));
      if (c % 3 == 2 && c < 11) begin
        Host_Addr  = up_addr[c / 3 + 1];
        Host_WData = up_data[c / 3 + 1];
      end
    end
    Host_Lock = 0; Host_We = 0;
    for (int c = 12; c <= 14; c++) begin
      tick();
      chk($sformatf("unlock c%0d cpu_ack", c),  32'(CPU_Ack),  32'(c == 14));
      chk($sformatf("unlock c%0d host_ack", c), 32'(Host_Ack), 32'd0);
    end
    chk("unlock rdata", 32'(RData), 32'hB17F);
    CPU_Req = 0; Host_Req = 0;
    tick();

    // Last uploaded word must have landed.
    Host_Req = 1; Host_We = 0; Host_Addr = 8'h81;
    tick();
    Host_Req = 0;
    tick();
    chk("readback host_ack", 32'(Host_Ack), 32'd1);
    chk("readback rdata",    32'(RData),    32'h5A03);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
